// File: rtl/drf_bus_pkg.sv
// drf_bus_pkg: shared constants, requester indices and arbiter state encoding for the 8-bit bus.
package drf_bus_pkg;
  localparam int NUM_REQ = 4;
  localparam int DATA_W = 8;
  localparam int REQ_CU = 0;
  localparam int REQ_ALU = 1;
  localparam int REQ_REG = 2;
  localparam int REQ_DMEM = 3;
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: one-hot winner of a round-robin search starting at start, skipping excluded requesters.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  exclude,
  output logic [N-1:0]  winner
);
  logic [N-1:0] cand;
  logic [N-1:0] pos;
  always_comb begin
    cand = req & ~exclude;
    winner = '0;
    pos = '0;
    // farthest first, so the nearest asserted candidate overwrites last
    for (int k = N - 1; k >= 0; k--) begin
      pos = N'(1) << ((int'(start) + k) % N);
      winner = |(cand & pos) ? pos : winner;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter with lock hold for the shared bus; BUS_ARBITER_TIMEOUT_EN bounds lock duration.
module bus_arbiter
  import drf_bus_pkg::*;
#(
  parameter int NUM_REQ = drf_bus_pkg::NUM_REQ,
  parameter int DATA_W = drf_bus_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_req,
  input  logic [NUM_REQ-1:0]        in_lock,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        out_grant,
  output logic [DATA_W-1:0]         out_bus,
  output logic                      out_bus_valid,
  output logic                      out_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] last, start, win_idx;
  logic [NUM_REQ-1:0] winner, exclude;
  logic expire, keep;
  state_t state;
  always_comb begin
    state = ~|out_grant ? IDLE : |(out_grant & in_req & in_lock) ? LOCKED : GRANT;
    keep = (state == LOCKED) && !expire;
    exclude = expire ? out_grant : '0;
    start = (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) win_idx = winner[i] ? IW'(i) : win_idx;
    out_bus = '0;
    for (int i = 0; i < NUM_REQ; i++) out_bus = out_grant[i] ? in_data[i*DATA_W +: DATA_W] : out_bus;
    out_bus_valid = |out_grant;
  end
  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req(in_req),
    .start(start),
    .exclude(exclude),
    .winner(winner)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_grant <= '0;
      last <= IW'(NUM_REQ - 1);
    end else if (!keep) begin
      out_grant <= winner;
      if (|winner) last <= win_idx;
    end
  end
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic timeout_q;
  assign expire = (state == LOCKED) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign out_timeout = timeout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      cnt <= keep ? cnt + 1'b1 : '0;
    end
  end
`else
  assign expire = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign out_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter; honours BUS_ARBITER_TIMEOUT_EN when defined.
module tb_bus_arbiter;
  import drf_bus_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] in_req, in_lock;
  logic [31:0] in_data;
  logic [3:0] out_grant;
  logic [7:0] out_bus;
  logic out_bus_valid, out_timeout;
  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk),
    .rst(rst),
    .in_req(in_req),
    .in_lock(in_lock),
    .in_data(in_data),
    .out_grant(out_grant),
    .out_bus(out_bus),
    .out_bus_valid(out_bus_valid),
    .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [7:0] b);
    check({tag, ".grant"}, 32'(out_grant), 32'(g));
    check({tag, ".bus"}, 32'(out_bus), 32'(b));
    check({tag, ".valid"}, 32'(out_bus_valid), 32'(|g));
  endtask

  logic [3:0] rr_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    rst = 1'b1;
    in_req = '0;
    in_lock = '0;
    in_data = 32'h4433_2211;
    tick();
    tick();
    expect_out("reset", 4'b0000, 8'h00);
    check("reset.timeout", 32'(out_timeout), 32'd0);
    rst = 1'b0;
    // round robin over all four requesters
    in_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("rr%0d", i), rr_g[i], rr_b[i]);
    end
    in_req = '0;
    tick();
    expect_out("rr_idle", 4'b0000, 8'h00);
    // locks without requests are ignored
    in_lock = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("lock_noreq%0d", i), 4'b0000, 8'h00);
    end
    // locked hold for six cycles, then hand-over with no gap
    in_req = 4'b0100;
    in_lock = 4'b0100;
    tick();
    expect_out("lock_c1", 4'b0100, 8'h33);
    in_req = 4'b0110;
    for (int i = 2; i <= 6; i++) begin
      tick();
      expect_out($sformatf("lock_c%0d", i), 4'b0100, 8'h33);
    end
    in_req = 4'b0010;
    in_lock = '0;
    tick();
    expect_out("lock_handover", 4'b0010, 8'h22);
    in_req = '0;
    tick();
    expect_out("handover_idle", 4'b0000, 8'h00);
    // single pulse from data memory
    in_data[REQ_DMEM*8 +: 8] = 8'hA5;
    in_req[REQ_DMEM] = 1'b1;
    tick();
    expect_out("pulse", 4'b1000, 8'hA5);
    in_req = '0;
    tick();
    expect_out("pulse_end", 4'b0000, 8'h00);
    // reset during a lock held by the ALU
    in_req[REQ_ALU] = 1'b1;
    in_lock[REQ_ALU] = 1'b1;
    tick();
    expect_out("alu_lock", 4'b0010, 8'h22);
    tick();
    expect_out("alu_hold", 4'b0010, 8'h22);
    rst = 1'b1;
    in_req = 4'b0011;
    tick();
    expect_out("rst_mid_lock", 4'b0000, 8'h00);
    rst = 1'b0;
    in_lock = '0;
    tick();
    expect_out("post_rst0", 4'b0001, 8'h11);
    tick();
    expect_out("post_rst1", 4'b0010, 8'h22);
    // long lock by the register bank with data memory waiting
    rst = 1'b1;
    in_req = '0;
    tick();
    rst = 1'b0;
    in_req = 4'b1100;
    in_lock = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      tick();
`ifdef BUS_ARBITER_TIMEOUT_EN
      check($sformatf("to_grant%0d", k), 32'(out_grant), k < 16 ? 32'h4 : 32'h8);
      check($sformatf("to_pulse%0d", k), 32'(out_timeout), k < 16 ? 32'd0 : 32'd1);
`else
      check($sformatf("to_grant%0d", k), 32'(out_grant), 32'h4);
      check($sformatf("to_pulse%0d", k), 32'(out_timeout), 32'd0);
`endif
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
